// File: rtl/pipeline_bus_arbiter_pkg.sv
// Shared definitions for the pipeline bus arbiter: one-hot arbiter states
// and the bus owner codes reported on BusOwner.
package pipeline_bus_pkg;

    typedef enum logic [3:0] {
        S_CPU    = 4'b0001,
        S_TURN_D = 4'b0010,
        S_DMA    = 4'b0100,
        S_TURN_C = 4'b1000
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_CPU  = 2'd0,
        OWN_TURN = 2'd1,
        OWN_DMA  = 2'd2
    } bus_owner_t;

endpackage

// File: rtl/pipeline_bus_arbiter_if.sv
// Request/grant bundle between pipeline stage 2, the DMA requester and the
// bus arbiter. The requesters drive the master side; the arbiter is the slave.
interface pipeline_bus_arbiter_if;

    logic       CpuBusRequest;
    logic       CpuBreak;
    logic       DmaReq;
    logic       DmaGrant;
    logic       CpuBusEnable;
    logic       PipeStall;
    logic [1:0] BusOwner;
    logic       DmaRevoked;

    modport master (
        output CpuBusRequest,
        output CpuBreak,
        output DmaReq,
        input  DmaGrant,
        input  CpuBusEnable,
        input  PipeStall,
        input  BusOwner,
        input  DmaRevoked
    );

    modport slave (
        input  CpuBusRequest,
        input  CpuBreak,
        input  DmaReq,
        output DmaGrant,
        output CpuBusEnable,
        output PipeStall,
        output BusOwner,
        output DmaRevoked
    );

endinterface

// File: rtl/pipeline_bus_arbiter_bus_sat_counter.sv
// Small saturating up/down counter used for the arbiter's starvation,
// CPU hold-off and burst-length tracking. LIMIT is both the saturation
// point for counting up and the value loaded by load. The single flag
// reports either "at LIMIT" or "at zero", chosen by FLAG_ZERO.
module bus_sat_counter #(
    parameter int CNT_W     = 5,
    parameter int LIMIT     = 8,
    parameter bit FLAG_ZERO = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic inc,
    input  logic dec,
    output logic flag
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    // Count state: clear beats load beats inc beats dec; inc/dec stop at the ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LIM;
        end else if (inc) begin
            if (cnt != LIM) cnt <= cnt + 1'b1;
        end else if (dec) begin
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end

    assign flag = FLAG_ZERO ? (cnt == '0) : (cnt == LIM);

endmodule

// File: rtl/pipeline_bus_arbiter.sv
// Arbitrates the CPU main bus between pipeline stage 2 and a DMA requester.
// Every ownership change passes through a dead turnaround cycle so the two
// masters never drive the bus together. All outputs except PipeStall are
// registered alongside the state, so they cannot glitch.
module pipeline_bus_arbiter
    import pipeline_bus_pkg::*;
#(
    parameter int MAX_BURST    = 16,
    parameter int STARVE_LIMIT = 8,
    parameter int MIN_CPU      = 4,
    parameter int CNT_W        = 5
) (
    input  logic                  ClockIn,
    input  logic                  ResetIn,
    pipeline_bus_arbiter_if.slave bus
);

    arb_state_t state;
    bus_owner_t owner_q;
    logic       cpu_en_q;
    logic       grant_q;
    logic       revoked_q;

    logic starve_full;
    logic mincpu_done;
    logic burst_full;

    logic starve_inc;
    logic starve_clr;
    logic mincpu_load;
    logic mincpu_dec;
    logic burst_clr;
    logic burst_inc;

    logic dma_go;
    logic burst_revoke;

    // A DMA request waiting behind an active CPU request builds up starvation.
    assign starve_inc  = (state == S_CPU) && bus.DmaReq && bus.CpuBusRequest;
    assign starve_clr  = !starve_inc;

    // The CPU hold-off window starts as the bus comes back from DMA.
    assign mincpu_load = (state == S_TURN_C);
    assign mincpu_dec  = (state == S_CPU);

    // Burst length is measured from the first granted cycle.
    assign burst_clr   = (state == S_TURN_D) && bus.DmaReq;
    assign burst_inc   = (state == S_DMA);

    // Hand over at an instruction gap, when the CPU is halted, or once DMA has
    // starved long enough; never inside the CPU hold-off unless halted.
    assign dma_go = bus.DmaReq
                  && (mincpu_done || bus.CpuBreak)
                  && (!bus.CpuBusRequest || bus.CpuBreak || starve_full);

    // A halted CPU never takes the bus back from DMA.
    assign burst_revoke = burst_full && bus.CpuBusRequest && !bus.CpuBreak;

    bus_sat_counter #(
        .CNT_W    (CNT_W),
        .LIMIT    (STARVE_LIMIT),
        .FLAG_ZERO(1'b0)
    ) u_starve_cnt (
        .clk (ClockIn),
        .rst (ResetIn),
        .clr (starve_clr),
        .load(1'b0),
        .inc (starve_inc),
        .dec (1'b0),
        .flag(starve_full)
    );

    bus_sat_counter #(
        .CNT_W    (CNT_W),
        .LIMIT    (MIN_CPU),
        .FLAG_ZERO(1'b1)
    ) u_mincpu_cnt (
        .clk (ClockIn),
        .rst (ResetIn),
        .clr (1'b0),
        .load(mincpu_load),
        .inc (1'b0),
        .dec (mincpu_dec),
        .flag(mincpu_done)
    );

    bus_sat_counter #(
        .CNT_W    (CNT_W),
        .LIMIT    (MAX_BURST - 1),
        .FLAG_ZERO(1'b0)
    ) u_burst_cnt (
        .clk (ClockIn),
        .rst (ResetIn),
        .clr (burst_clr),
        .load(1'b0),
        .inc (burst_inc),
        .dec (1'b0),
        .flag(burst_full)
    );

    // Ownership FSM; the output flops are updated with the state they decode.
    always_ff @(posedge ClockIn or posedge ResetIn) begin
        if (ResetIn) begin
            state     <= S_CPU;
            owner_q   <= OWN_CPU;
            cpu_en_q  <= 1'b1;
            grant_q   <= 1'b0;
            revoked_q <= 1'b0;
        end else begin
            revoked_q <= 1'b0;
            unique case (state)
                S_CPU: begin
                    if (dma_go) begin
                        state    <= S_TURN_D;
                        owner_q  <= OWN_TURN;
                        cpu_en_q <= 1'b0;
                    end
                end
                S_TURN_D: begin
                    if (bus.DmaReq) begin
                        state   <= S_DMA;
                        owner_q <= OWN_DMA;
                        grant_q <= 1'b1;
                    end else begin
                        // Request withdrawn during turnaround: hand straight back.
                        state <= S_TURN_C;
                    end
                end
                S_DMA: begin
                    if (!bus.DmaReq) begin
                        state   <= S_TURN_C;
                        owner_q <= OWN_TURN;
                        grant_q <= 1'b0;
                    end else if (burst_revoke) begin
                        state     <= S_TURN_C;
                        owner_q   <= OWN_TURN;
                        grant_q   <= 1'b0;
                        revoked_q <= 1'b1;
                    end
                end
                S_TURN_C: begin
                    state    <= S_CPU;
                    owner_q  <= OWN_CPU;
                    cpu_en_q <= 1'b1;
                end
                default: begin
                    state    <= S_CPU;
                    owner_q  <= OWN_CPU;
                    cpu_en_q <= 1'b1;
                    grant_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CpuBusEnable = cpu_en_q;
    assign bus.DmaGrant     = grant_q;
    assign bus.BusOwner     = owner_q;
    assign bus.DmaRevoked   = revoked_q;
    assign bus.PipeStall    = bus.CpuBusRequest & ~cpu_en_q;

endmodule

// File: doc/pipeline_bus_arbiter.md
Name: pipeline_bus_arbiter

Overview:
- Shares the CPU main bus between pipeline stage 2 and an external DMA requester.
- Stage 2 asks for the bus with its BusRequest control line (Pipe2Out_13_BusRequest).
- The block grants the bus to DMA at instruction gaps, or by force after CPU starvation, and stalls the pipeline while the CPU lacks the bus.
- It inserts one dead turnaround cycle on every ownership change, so CPU and DMA never drive the bus together.

Parameters:
- MAX_BURST, 16: DMA grant cycles allowed before revocation when the CPU has a request pending.
- STARVE_LIMIT, 8: consecutive cycles a DMA request may wait behind CPU requests before ownership is forced to DMA.
- MIN_CPU, 4: cycles the CPU keeps the bus after regaining it before DMA may be granted again.
- CNT_W, 5: width of the internal counters; must satisfy 2^CNT_W > max(MAX_BURST, STARVE_LIMIT, MIN_CPU).

Ports:
- ClockIn, in, 1: sole clock; all state changes on the rising edge.
- ResetIn, in, 1: asynchronous, active-high reset.
- CpuBusRequest, in, 1: stage-2 BusRequest control output.
- CpuBreak, in, 1: stage-2 Break output; CPU halted, DMA is unrestricted.
- DmaReq, in, 1: DMA level request; held high for the whole transfer.
- DmaGrant, out, 1: DMA owns and may drive the bus.
- CpuBusEnable, out, 1: CPU owns the bus; gates CPU bus drivers.
- PipeStall, out, 1: freeze pipeline registers.
- BusOwner, out, 2: 0 = CPU, 1 = turnaround, 2 = DMA.
- DmaRevoked, out, 1: one-cycle pulse when a grant was removed by the burst limit.

Behaviour:
- States: S_CPU, S_TURN_D, S_DMA, S_TURN_C. One-hot encoded. All outputs except PipeStall are Moore decodes of registered state/flags, so they are glitch-free.
- Reset (async, immediate):
  - state = S_CPU; all counters = 0.
  - CpuBusEnable = 1, DmaGrant = 0, BusOwner = 0, DmaRevoked = 0, PipeStall = 0.
- Outputs by state:
  - CpuBusEnable = 1 only in S_CPU.
  - DmaGrant = 1 only in S_DMA.
  - Both are 0 in the two TURN states.
  - PipeStall = CpuBusRequest & ~CpuBusEnable (combinational). This is the only combinational output.
- starve_cnt:
  - In S_CPU with DmaReq & CpuBusRequest: increments, saturating at STARVE_LIMIT.
  - Otherwise: cleared.
- mincpu_cnt:
  - Loaded with MIN_CPU on S_TURN_C -> S_CPU.
  - In S_CPU: decrements to 0.
- burst_cnt:
  - Cleared on S_TURN_D -> S_DMA.
  - Increments each S_DMA cycle, saturating at MAX_BURST-1.
- Transitions from S_CPU:
  - Goes to S_TURN_D when DmaReq & (mincpu_cnt==0 | CpuBreak) & (~CpuBusRequest | CpuBreak | starve_cnt==STARVE_LIMIT).
  - Otherwise stays in S_CPU.
- Transitions from S_TURN_D:
  - Goes to S_DMA if DmaReq, else to S_TURN_C (request withdrawn during turnaround).
- Transitions from S_DMA, in priority order:
  - ~DmaReq -> S_TURN_C.
  - burst_cnt==MAX_BURST-1 & CpuBusRequest & ~CpuBreak -> S_TURN_C, with DmaRevoked set for the S_TURN_C cycle.
  - Otherwise stay in S_DMA.
- Transitions from S_TURN_C: always to S_CPU.
- Latency:
  - DmaReq sampled high in idle S_CPU at edge N gives S_TURN_D at N and DmaGrant high after edge N+1.
  - DmaReq dropped before edge M gives CpuBusEnable high after edge M+1.
- Boundary rules:
  - With no CPU request pending, a DMA burst is unlimited.
  - When CpuBreak is high, revocation and the MIN_CPU hold-off are both suppressed.
  - DMA must keep DmaReq high until it sees DmaGrant. A revoked DMA re-requests simply by keeping DmaReq high; it is re-granted after MIN_CPU CPU cycles plus the normal arbitration.
  - Reset mid-DMA drops DmaGrant immediately (asynchronous) and returns the bus to the CPU.

Decomposition:
- Shared include/package pipeline_bus_pkg holds:
  - state encodings S_CPU, S_TURN_D, S_DMA, S_TURN_C;
  - BusOwner codes OWN_CPU=0, OWN_TURN=1, OWN_DMA=2.
- One natural sub-module, bus_sat_counter: parameterised width and limit, with clear, load, inc and dec controls and an at-limit/zero output. It is instantiated three times (starve, mincpu, burst).

Test Plan:
- Idle grant: CpuBusRequest=0; raise DmaReq at cycle 0 -> BusOwner 1 at cycle 1, DmaGrant=1 at cycle 2. Drop DmaReq at cycle 10 -> turnaround at 11, CpuBusEnable=1 at 12; PipeStall is 0 throughout.
- Starvation: CpuBusRequest held 1, DmaReq held 1 -> CPU keeps the bus 9 cycles (starve_cnt reaches 8), then turnaround; PipeStall=1 from the turnaround cycle until the CPU regains the bus.
- Revocation: DMA owns the bus, CpuBusRequest=1, DmaReq held -> after exactly 16 DmaGrant cycles: DmaRevoked pulses for 1 cycle, BusOwner=1, then CPU for at least 4 cycles before the next DMA turnaround.
- Break: CpuBreak=1, CpuBusRequest=1, DmaReq=1 -> grant with no starvation wait; DMA kept for more than 40 cycles, no revocation.
- Withdrawn request: DmaReq pulses 1 cycle -> S_TURN_D, then S_TURN_C, then S_CPU; DmaGrant never asserted.
- Async reset during S_DMA: ResetIn mid-cycle -> DmaGrant=0 and CpuBusEnable=1 before the next clock edge; all counters at 0 after release.
